// File: rtl/booth_mult_pkg.sv
// Shared constants and types for the booth_mult sequential multiplier.
// BOOTH_MULT_RADIX4_EN selects radix-4 recoding (2 bits per step); otherwise radix-2.
package booth_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

`ifdef BOOTH_MULT_RADIX4_EN
    localparam int STEP_BITS = 2;
`else
    localparam int STEP_BITS = 1;
`endif

    typedef enum logic {
        IDLE,
        CALC
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        ADD1,
        SUB1,
        ADD2,
        SUB2
    } booth_op_e;

    // Number of Booth steps needed to consume all multiplier bits.
    function automatic int step_count(input int width);
        return width / STEP_BITS;
    endfunction

endpackage

// File: rtl/booth_mult_if.sv
// Start/busy/done handshake and operand/result bus of the shared multiplier.
interface booth_mult_if #(
    parameter int WIDTH = 8
);
    logic                      start;
    logic signed [WIDTH-1:0]   x;
    logic signed [WIDTH-1:0]   y;
    logic signed [2*WIDTH-1:0] p;
    logic                      busy;
    logic                      done;

    modport master (
        output start, x, y,
        input  p, busy, done
    );

    modport slave (
        input  start, x, y,
        output p, busy, done
    );
endinterface

// File: rtl/booth_recoder.sv
// Booth recoder: maps the examined multiplier bits to an operation and a sign-extended addend.
// With BOOTH_MULT_RADIX4_EN the input is the triplet {y[1], y[0], q(-1)}, otherwise the pair {y[0], q(-1)}.
module booth_recoder
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [STEP_BITS:0]           bits,
    input  logic [WIDTH-1:0]             x,
    output booth_op_e                    op,
    output logic [WIDTH+STEP_BITS-1:0]   addend
);

    logic [WIDTH+STEP_BITS-1:0] x_ext;

    // Extra sign bits keep +/-x and +/-2x exact, including x = -2^(WIDTH-1).
    assign x_ext = {{STEP_BITS{x[WIDTH-1]}}, x};

    always_comb begin
        // NOTE: default first so every path assigns op; a missing branch would infer a latch.
        op = NONE;
`ifdef BOOTH_MULT_RADIX4_EN
        case (bits)
            3'b001, 3'b010: op = ADD1;
            3'b011:         op = ADD2;
            3'b100:         op = SUB2;
            3'b101, 3'b110: op = SUB1;
            default:        op = NONE;
        endcase
`else
        case (bits)
            2'b01:   op = ADD1;
            2'b10:   op = SUB1;
            default: op = NONE;
        endcase
`endif
    end

    always_comb begin
        addend = '0;
        case (op)
            ADD1:    addend = x_ext;
            SUB1:    addend = -x_ext;
            ADD2:    addend = x_ext << 1;
            SUB2:    addend = -(x_ext << 1);
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed Booth multiplier with start/busy/done handshake and full-width product.
// BOOTH_MULT_RADIX4_EN halves the latency (radix-4); the result is identical in both builds.
module booth_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    booth_mult_if.slave bus
);

    localparam int EXT   = WIDTH + STEP_BITS;
    localparam int STEPS = step_count(WIDTH);
    localparam int CNT_W = $clog2(STEPS + 1);

    state_e              state;
    logic [WIDTH-1:0]    x_reg;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    q;
    logic                q_m1;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH-1:0]  product;
    logic                busy_r;
    logic                done_r;

    booth_op_e           op;
    logic [EXT-1:0]      addend;
    logic [EXT-1:0]      acc_ext;
    logic [EXT-1:0]      sum;
    logic [WIDTH-1:0]    acc_next;
    logic [WIDTH-1:0]    q_next;

    booth_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .bits   ({q[STEP_BITS-1:0], q_m1}),
        .x      (x_reg),
        .op     (op),
        .addend (addend)
    );

    assign acc_ext = {{STEP_BITS{acc[WIDTH-1]}}, acc};
    assign sum     = (op == NONE) ? acc_ext : acc_ext + addend;

    // Arithmetic shift of {sum, q, q_m1}: the wide sum's redundant sign bits drop off the top.
    assign acc_next = sum[EXT-1:STEP_BITS];
    assign q_next   = {sum[STEP_BITS-1:0], q[WIDTH-1:STEP_BITS]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_reg   <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_reg  <= bus.x;
                        acc    <= '0;
                        q      <= bus.y;
                        q_m1   <= 1'b0;
                        cnt    <= CNT_W'(STEPS);
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    q    <= q_next;
                    q_m1 <= q[STEP_BITS-1];
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        product <= {acc_next, q_next};
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p    = product;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_booth_mult.sv
// Directed self-checking bench for booth_mult: reset, corners, back-to-back, busy/abort cases.
module tb_booth_mult;

    localparam int W = 8;
`ifdef BOOTH_MULT_RADIX4_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    booth_mult_if #(.WIDTH(W)) bus ();

    booth_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic int p_val();
        return int'(bus.p);
    endfunction

    // One operation; operands are zeroed right after acceptance.
    task automatic do_mult(input string tag, input int a, input int b, input int exp);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        bus.x     = W'(a);
        bus.y     = W'(b);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        check({tag, "_busy"}, int'(bus.busy), 1);
        while (!seen && n < 4 * LAT) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.done;
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        check({tag, "_latency"}, n, LAT);
        check({tag, "_p"}, p_val(), exp);
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, int'(bus.done), 0);
        check({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    int xs [10] = '{-128, -127, -65, -1, 0, 1, 2, 63, 100, 127};
    int ys [10] = '{-128, -100, -33, -2, -1, 0, 1, 5, 64, 127};

    initial begin
        int n;
        int dones;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        #12;
        check("rst_p", p_val(), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_p", p_val(), 0);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_done", int'(bus.done), 0);

        do_mult("neg_neg", -128, -128, 16384);
        do_mult("neg_pos", -128, 127, -16256);
        do_mult("pos_pos", 127, 127, 16129);
        do_mult("m1_p1", -1, 1, -1);
        do_mult("zero", 0, -5, 0);
        do_mult("opnd_change", -7, 9, -63);

        // Back-to-back: start stays high and the next operands are set in each done cycle.
        @(negedge clk);
        bus.x     = W'(xs[0]);
        bus.y     = W'(ys[0]);
        bus.start = 1'b1;
        for (int k = 0; k < 100; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.done && n < 4 * LAT);
            check($sformatf("b2b_lat_%0d", k), n, LAT + 1);
            check($sformatf("b2b_p_%0d_x%0d_y%0d", k, xs[k / 10], ys[k % 10]),
                  p_val(), xs[k / 10] * ys[k % 10]);
            if (k == 99) begin
                bus.start = 1'b0;
            end else begin
                bus.x = W'(xs[(k + 1) / 10]);
                bus.y = W'(ys[(k + 1) % 10]);
            end
        end
        repeat (2) @(posedge clk);

        // Start while busy is ignored.
        @(negedge clk);
        bus.x     = W'(3);
        bus.y     = W'(5);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.x     = W'(7);
        bus.y     = W'(7);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        repeat (4 * LAT) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_p", p_val(), 15);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        bus.x     = W'(10);
        bus.y     = W'(10);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_p", p_val(), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (3 * LAT) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_p_held", p_val(), 0);
        do_mult("rst_recover", 10, 10, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
